// File: rtl/uart_cmd_framer.sv
// rtl/uart_cmd_framer.sv - UART command/response framer with an 8N1 UART core
// Optional per-frame checksum byte is enabled by defining UART_CMD_CHKSUM_EN.

module uart_cmd_framer_uart #(
    parameter int BAUD_CLKS = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic       TX,
    output logic       rx_rdy,
    output logic [7:0] rx_data,
    input  logic       clr_rx_rdy,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       tx_done
);
    localparam int BW = $clog2(BAUD_CLKS + 1);

    logic [1:0]    rx_sync_q;
    logic          rx_busy_q, rx_rdy_q, tx_done_q;
    logic [BW-1:0] rx_baud_q, tx_baud_q;
    logic [3:0]    rx_bits_q, tx_bits_q;
    logic [7:0]    rx_shift_q;
    logic [9:0]    tx_shift_q;

    // Start edge waits half a bit so every later sample lands mid-bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_q  <= 2'b11;
            rx_busy_q  <= 1'b0;
            rx_baud_q  <= '0;
            rx_bits_q  <= 4'd0;
            rx_shift_q <= 8'h00;
            rx_rdy_q   <= 1'b0;
        end else begin
            rx_sync_q <= {rx_sync_q[0], RX};
            if (clr_rx_rdy) rx_rdy_q <= 1'b0;
            if (!rx_busy_q) begin
                if (!rx_sync_q[1]) begin
                    rx_busy_q <= 1'b1;
                    rx_baud_q <= BW'(BAUD_CLKS / 2);
                    rx_bits_q <= 4'd0;
                end
            end else if (rx_baud_q == '0) begin
                rx_baud_q <= BW'(BAUD_CLKS - 1);
                rx_bits_q <= rx_bits_q + 4'd1;
                if (rx_bits_q == 4'd0) begin
                    if (rx_sync_q[1]) rx_busy_q <= 1'b0;
                end else if (rx_bits_q <= 4'd8) begin
                    rx_shift_q <= {rx_sync_q[1], rx_shift_q[7:1]};
                end else begin
                    rx_busy_q <= 1'b0;
                    if (rx_sync_q[1]) rx_rdy_q <= 1'b1;
                end
            end else begin
                rx_baud_q <= rx_baud_q - 1'b1;
            end
        end
    end

    // tx_done is sticky until the next trmt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift_q <= '1;
            tx_bits_q  <= 4'd0;
            tx_baud_q  <= '0;
            tx_done_q  <= 1'b0;
        end else if (trmt) begin
            tx_shift_q <= {1'b1, tx_data, 1'b0};
            tx_bits_q  <= 4'd10;
            tx_baud_q  <= BW'(BAUD_CLKS - 1);
            tx_done_q  <= 1'b0;
        end else if (tx_bits_q != 4'd0) begin
            if (tx_baud_q == '0) begin
                tx_baud_q  <= BW'(BAUD_CLKS - 1);
                tx_shift_q <= {1'b1, tx_shift_q[9:1]};
                tx_bits_q  <= tx_bits_q - 4'd1;
                if (tx_bits_q == 4'd1) tx_done_q <= 1'b1;
            end else begin
                tx_baud_q <= tx_baud_q - 1'b1;
            end
        end
    end

    assign TX      = tx_shift_q[0];
    assign rx_rdy  = rx_rdy_q;
    assign rx_data = rx_shift_q;
    assign tx_done = tx_done_q;
endmodule

module uart_cmd_framer #(
    parameter int CMD_BYTES    = 2,
    parameter int RESP_BYTES   = 1,
    parameter int MSB_FIRST    = 1,
    parameter int TIMEOUT_CLKS = 0,
    parameter int BAUD_CLKS    = 434
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    RX,
    output logic                    TX,
    output logic [8*CMD_BYTES-1:0]  cmd,
    output logic                    cmd_rdy,
    input  logic                    clr_cmd_rdy,
    input  logic [8*RESP_BYTES-1:0] resp,
    input  logic                    send_resp,
    output logic                    resp_busy,
    output logic                    resp_done,
    output logic                    frame_err
);
`ifdef UART_CMD_CHKSUM_EN
    localparam int FRAME = CMD_BYTES + 1;
`else
    localparam int FRAME = CMD_BYTES;
`endif
    localparam int CW = $clog2(FRAME + 1);
    localparam int TW = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;
    localparam int IW = $clog2(RESP_BYTES + 1);
    localparam int CB = 8 * CMD_BYTES;
    localparam int RB = 8 * RESP_BYTES;

    typedef enum logic       {IDLE, COLLECT} rx_state_t;
    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;

    logic          rx_rdy, clr_rx_rdy, tx_done, trmt_q;
    logic [7:0]    rx_data, tx_data_q;
    rx_state_t     rx_state_q;
    tx_state_t     tx_state_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tmo_q;
    logic [CB-1:0] shadow_q, shadow_d, cmd_q;
    logic [RB-1:0] resp_sh_q;
    logic [IW-1:0] idx_q;
    logic          cmd_rdy_q, frame_err_q, resp_busy_q, resp_done_q, wait_first_q;
    logic          last_byte, frame_ok;

    uart_cmd_framer_uart #(.BAUD_CLKS(BAUD_CLKS)) u_uart (
        .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy),
        .trmt(trmt_q), .tx_data(tx_data_q), .tx_done(tx_done)
    );

    assign clr_rx_rdy = rx_rdy;
    assign last_byte  = (cnt_q == CW'(FRAME - 1));

    always_comb begin
        shadow_d = shadow_q;
        for (int k = 0; k < CMD_BYTES; k++) begin
            if (k == int'(cnt_q)) begin
                if (MSB_FIRST != 0) shadow_d[8*(CMD_BYTES-k)-1 -: 8] = rx_data;
                else                shadow_d[8*k+7 -: 8]             = rx_data;
            end
        end
    end

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      sum_q <= 8'h00;
        else if (rx_rdy) sum_q <= (rx_state_q == IDLE) ? rx_data : sum_q + rx_data;
    end

    assign frame_ok = ((sum_q + rx_data) == 8'h00);
`else
    assign frame_ok = 1'b1;
`endif

    // A byte in the expiry cycle takes the rx_rdy branch, so the byte wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_q  <= IDLE;
            cnt_q       <= '0;
            tmo_q       <= '0;
            shadow_q    <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            if (clr_cmd_rdy || (rx_rdy && rx_state_q == IDLE)) cmd_rdy_q <= 1'b0;
            if (rx_rdy) begin
                shadow_q <= shadow_d;
                tmo_q    <= '0;
                if (last_byte) begin
                    cnt_q      <= '0;
                    rx_state_q <= IDLE;
                    if (frame_ok) begin
                        cmd_q     <= shadow_d;
                        cmd_rdy_q <= 1'b1;
                    end else begin
                        frame_err_q <= 1'b1;
                    end
                end else begin
                    cnt_q      <= cnt_q + 1'b1;
                    rx_state_q <= COLLECT;
                end
            end else if (rx_state_q == COLLECT && TIMEOUT_CLKS > 0) begin
                if (tmo_q == TW'(TIMEOUT_CLKS)) begin
                    cnt_q       <= '0;
                    tmo_q       <= '0;
                    rx_state_q  <= IDLE;
                    frame_err_q <= 1'b1;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    // First T_WAIT cycle still sees the previous byte's sticky tx_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q   <= T_IDLE;
            resp_sh_q    <= '0;
            idx_q        <= '0;
            tx_data_q    <= 8'h00;
            trmt_q       <= 1'b0;
            resp_busy_q  <= 1'b0;
            resp_done_q  <= 1'b0;
            wait_first_q <= 1'b0;
        end else begin
            trmt_q      <= 1'b0;
            resp_done_q <= 1'b0;
            case (tx_state_q)
                T_IDLE: if (send_resp) begin
                    resp_sh_q   <= resp;
                    idx_q       <= '0;
                    resp_busy_q <= 1'b1;
                    tx_state_q  <= T_SEND;
                end
                T_SEND: begin
                    trmt_q       <= 1'b1;
                    wait_first_q <= 1'b1;
                    tx_state_q   <= T_WAIT;
                    if (MSB_FIRST != 0) begin
                        tx_data_q <= resp_sh_q[RB-1 -: 8];
                        resp_sh_q <= resp_sh_q << 8;
                    end else begin
                        tx_data_q <= resp_sh_q[7:0];
                        resp_sh_q <= resp_sh_q >> 8;
                    end
                end
                T_WAIT: begin
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (tx_done) begin
                        if (idx_q == IW'(RESP_BYTES - 1)) begin
                            resp_done_q <= 1'b1;
                            resp_busy_q <= 1'b0;
                            tx_state_q  <= T_IDLE;
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            tx_state_q <= T_SEND;
                        end
                    end
                end
                default: tx_state_q <= T_IDLE;
            endcase
        end
    end

    assign cmd       = cmd_q;
    assign cmd_rdy   = cmd_rdy_q;
    assign frame_err = frame_err_q;
    assign resp_busy = resp_busy_q;
    assign resp_done = resp_done_q;
endmodule
